// File: rtl/timed_overlay.sv
// rtl/timed_overlay.sv - time-limited framed progress-bar overlay for a pixel stream
//
// Purpose:
//   On a rising edge of state_in into TRIG_STATE the overlay becomes active
//   for DURATION clk cycles. While active it draws a rectangular frame and a
//   progress bar that grows from left to right inside the frame. The bar
//   fills the inner width once over the active period. Completion pulses
//   finished_out. abort_in cancels the overlay without a pulse.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   hcount_in    in   [10:0] current pixel column
//   vcount_in    in   [9:0]  current pixel row
//   state_in     in   [3:0]  game state, watched for entry into TRIG_STATE
//   abort_in     in   cancels an active overlay
//   busy_out     out  high while the overlay is active
//   finished_out out  one-cycle pulse on normal completion
//   pixel_out    out  [11:0] overlay colour, 0 where transparent (1-cycle latency)

module timed_overlay #(
    parameter int          X0          = 128,
    parameter int          Y0          = 384,
    parameter int          W           = 768,
    parameter int          H           = 192,
    parameter int          BORDER      = 8,
    parameter logic [11:0] FRAME_COLOR = 12'hFFF,
    parameter logic [11:0] BAR_COLOR   = 12'h0F0,
    parameter int          DURATION    = 32500000,
    parameter logic [3:0]  TRIG_STATE  = 4'h0,
    parameter int          RETRIGGER   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic        abort_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic [11:0] pixel_out
);

    // Bar geometry: the bar spans the inner width once over DURATION cycles.
    localparam int IW       = W - 2 * BORDER;
    localparam int STEP_RAW = DURATION / IW;
    localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int CW       = $clog2(DURATION + 1);
    localparam int FW       = $clog2(IW + 1);
    localparam int SW       = $clog2(STEP + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DURATION - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(IW);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);

    // Rectangle edges held at 32 bits so no sum can wrap.
    localparam logic [31:0] OX0 = 32'(X0);
    localparam logic [31:0] OX1 = 32'(X0 + W);
    localparam logic [31:0] OY0 = 32'(Y0);
    localparam logic [31:0] OY1 = 32'(Y0 + H);
    localparam logic [31:0] IX0 = 32'(X0 + BORDER);
    localparam logic [31:0] IX1 = 32'(X0 + W - BORDER);
    localparam logic [31:0] IY0 = 32'(Y0 + BORDER);
    localparam logic [31:0] IY1 = 32'(Y0 + H - BORDER);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [FW-1:0] fill, fill_nx;
    logic [SW-1:0] step_cnt, step_cnt_nx;
    logic          finished_q, finished_nx;
    logic [3:0]    prev_state;
    logic [11:0]   pixel_q, pixel_nx;
    logic          trig;

    logic [31:0] h, v;
    logic        in_outer, in_inner, is_frame, is_bar;

    // Only a transition into TRIG_STATE triggers; holding it does not re-arm.
    assign trig = (state_in == TRIG_STATE) && (prev_state != TRIG_STATE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            fill       <= '0;
            step_cnt   <= '0;
            finished_q <= 1'b0;
            pixel_q    <= 12'h000;
            // Inverted so that TRIG_STATE right after reset is seen as a trigger.
            prev_state <= ~TRIG_STATE;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            fill       <= fill_nx;
            step_cnt   <= step_cnt_nx;
            finished_q <= finished_nx;
            pixel_q    <= pixel_nx;
            prev_state <= state_in;
        end
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        fill_nx     = fill;
        step_cnt_nx = step_cnt;
        finished_nx = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nx    = ACTIVE;
                    count_nx    = '0;
                    fill_nx     = '0;
                    step_cnt_nx = '0;
                end
            end
            ACTIVE: begin
                // Priority: abort, then retrigger, then completion, then run.
                if (abort_in) begin
                    state_nx    = IDLE;
                    count_nx    = '0;
                    fill_nx     = '0;
                    step_cnt_nx = '0;
                end else if (trig && (RETRIGGER != 0)) begin
                    count_nx    = '0;
                    fill_nx     = '0;
                    step_cnt_nx = '0;
                end else if (count == CNT_LAST) begin
                    state_nx    = IDLE;
                    count_nx    = '0;
                    fill_nx     = '0;
                    step_cnt_nx = '0;
                    finished_nx = 1'b1;
                end else begin
                    count_nx = count + CW'(1);
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_nx = '0;
                        if (fill != FILL_MAX) begin
                            fill_nx = fill + FW'(1);
                        end
                    end else begin
                        step_cnt_nx = step_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        h        = {21'b0, hcount_in};
        v        = {22'b0, vcount_in};
        in_outer = (h >= OX0) && (h < OX1) && (v >= OY0) && (v < OY1);
        in_inner = (h >= IX0) && (h < IX1) && (v >= IY0) && (v < IY1);
        is_frame = in_outer && !in_inner;
        is_bar   = in_inner && (h < (IX0 + 32'(fill)));
        pixel_nx = 12'h000;
        if (state == ACTIVE) begin
            if (is_frame) begin
                pixel_nx = FRAME_COLOR;
            end else if (is_bar) begin
                pixel_nx = BAR_COLOR;
            end
        end
    end

    assign busy_out     = (state == ACTIVE);
    assign finished_out = finished_q;
    assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_timed_overlay.sv
// tb/tb_timed_overlay.sv - self-checking bench for timed_overlay

module tb_timed_overlay;

    localparam logic [11:0] FC = 12'hFFF;
    localparam logic [11:0] BC = 12'h0F0;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [3:0]  state_in;
    logic        abort;

    logic        busy_a, fin_a, busy_b, fin_b, busy_c, fin_c;
    logic [11:0] pix_a, pix_b, pix_c;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // A: DURATION=20, no retrigger.  B: same with retrigger.  C: DURATION=100.
    timed_overlay #(.X0(10), .Y0(10), .W(20), .H(10), .BORDER(2),
                    .FRAME_COLOR(FC), .BAR_COLOR(BC), .DURATION(20),
                    .TRIG_STATE(4'h0), .RETRIGGER(0)) dut_a (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
        .state_in(state_in), .abort_in(abort),
        .busy_out(busy_a), .finished_out(fin_a), .pixel_out(pix_a));

    timed_overlay #(.X0(10), .Y0(10), .W(20), .H(10), .BORDER(2),
                    .FRAME_COLOR(FC), .BAR_COLOR(BC), .DURATION(20),
                    .TRIG_STATE(4'h0), .RETRIGGER(1)) dut_b (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
        .state_in(state_in), .abort_in(abort),
        .busy_out(busy_b), .finished_out(fin_b), .pixel_out(pix_b));

    timed_overlay #(.X0(10), .Y0(10), .W(20), .H(10), .BORDER(2),
                    .FRAME_COLOR(FC), .BAR_COLOR(BC), .DURATION(100),
                    .TRIG_STATE(4'h0), .RETRIGGER(0)) dut_c (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
        .state_in(state_in), .abort_in(abort),
        .busy_out(busy_c), .finished_out(fin_c), .pixel_out(pix_c));

    typedef struct {
        int          cnt;
        int          h;
        int          v;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t tbl[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        abort    = 1'b0;
        state_in = 4'h5;
        hcount   = '0;
        vcount   = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int cur;
        int fill_m;
        logic [11:0] e;

        // Fill counts strictly increase; each entry is sampled at that active count.
        tbl[0]  = '{0,  15, 15, 12'h000};
        tbl[1]  = '{1,  10, 10, FC};
        tbl[2]  = '{2,  9,  10, 12'h000};
        tbl[3]  = '{3,  29, 19, FC};
        tbl[4]  = '{4,  30, 15, 12'h000};
        tbl[5]  = '{5,  12, 12, BC};
        tbl[6]  = '{6,  17, 12, BC};
        tbl[7]  = '{7,  19, 12, 12'h000};
        tbl[8]  = '{8,  19, 17, BC};
        tbl[9]  = '{9,  12, 18, FC};
        tbl[10] = '{10, 11, 15, FC};
        tbl[11] = '{11, 28, 12, FC};
        tbl[12] = '{12, 20, 20, 12'h000};
        tbl[13] = '{16, 27, 15, BC};
        tbl[14] = '{18, 27, 15, BC};

        // Reset state
        do_reset();
        check("reset_busy_a", busy_a, 0);
        check("reset_fin_a", fin_a, 0);
        check("reset_pix_a", pix_a, 0);
        check("reset_busy_c", busy_c, 0);

        // Nominal completion: trigger at edge 1, busy 1..20, finished at 21
        do_reset();
        state_in = 4'h0;
        for (int j = 1; j <= 22; j++) begin
            step();
            check($sformatf("nom_busy_%0d", j), busy_a, (j <= 20));
            check($sformatf("nom_fin_%0d", j), fin_a, (j == 21));
        end

        // Abort at count 7
        do_reset();
        state_in = 4'h0;
        for (int j = 1; j <= 30; j++) begin
            step();
            check($sformatf("abort_busy_%0d", j), busy_a, (j <= 8));
            check($sformatf("abort_fin_%0d", j), fin_a, 0);
            abort = (j == 8);
        end

        // Abort held high while idle does not block a trigger
        do_reset();
        abort    = 1'b1;
        state_in = 4'h0;
        step();
        check("idle_abort_busy", busy_a, 1);
        step();
        check("idle_abort_busy2", busy_a, 0);
        check("idle_abort_fin", fin_a, 0);
        abort = 1'b0;

        // Retrigger 0->3->0 at count 10: B restarts at edge 12, A keeps its schedule
        do_reset();
        state_in = 4'h0;
        for (int j = 1; j <= 34; j++) begin
            step();
            check($sformatf("rt0_busy_%0d", j), busy_a, (j <= 20));
            check($sformatf("rt0_fin_%0d", j), fin_a, (j == 21));
            check($sformatf("rt1_busy_%0d", j), busy_b, (j <= 31));
            check($sformatf("rt1_fin_%0d", j), fin_b, (j == 32));
            if (j == 10) state_in = 4'h3;
            if (j == 11) state_in = 4'h0;
        end

        // Pixel map (A: STEP=1 so fill follows count up to 16)
        do_reset();
        state_in = 4'h0;
        step();
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            while (cur < tbl[i].cnt) begin
                step();
                cur++;
            end
            hcount = 11'(tbl[i].h);
            vcount = 10'(tbl[i].v);
            step();
            cur++;
            check($sformatf("pix_%0d_%0d_%0d", tbl[i].cnt, tbl[i].h, tbl[i].v), pix_a, tbl[i].exp);
        end
        while (cur < 21) begin
            step();
            cur++;
        end
        hcount = 11'd10;
        vcount = 10'd10;
        step();
        check("pix_idle_busy", busy_a, 0);
        check("pix_idle_frame", pix_a, 0);

        // Bar saturation on C: STEP=6, fill=16 from count 96 on
        do_reset();
        state_in = 4'h0;
        step();
        vcount = 10'd15;
        for (int c = 0; c < 100; c++) begin
            hcount = (c == 59 || c == 60) ? 11'd21 : 11'd27;
            fill_m = (c / 6 > 16) ? 16 : c / 6;
            e = (int'(hcount) < 12 + fill_m) ? BC : 12'h000;
            step();
            check($sformatf("sat_pix_%0d", c), pix_c, e);
            if (c < 99) check($sformatf("sat_busy_%0d", c), busy_c, 1);
        end
        check("sat_done_busy", busy_c, 0);
        check("sat_done_fin", fin_c, 1);
        step();
        check("sat_after_pix", pix_c, 0);
        check("sat_after_fin", fin_c, 0);

        // Reset mid-active at count 5, then TRIG_STATE right after reset triggers
        do_reset();
        state_in = 4'h0;
        step();
        for (int j = 0; j < 5; j++) step();
        rst    = 1'b1;
        hcount = 11'd10;
        vcount = 10'd10;
        step();
        check("midrst_busy", busy_a, 0);
        check("midrst_fin", fin_a, 0);
        check("midrst_pix", pix_a, 0);
        rst = 1'b0;
        step();
        check("postrst_busy", busy_a, 1);
        check("postrst_fin", fin_a, 0);
        check("postrst_pix", pix_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/timed_overlay.md
TIMED_OVERLAY -- requirements
Module: timed_overlay

Interface
REQ-001 SHALL have parameter X0, default 128, meaning the left edge of the overlay rectangle in pixels.
REQ-002 SHALL have parameter Y0, default 384, meaning the top edge of the rectangle in lines.
REQ-003 SHALL have parameter W, default 768, meaning the rectangle width in pixels.
REQ-004 SHALL have parameter H, default 192, meaning the rectangle height in lines.
REQ-005 SHALL have parameter BORDER, default 8, meaning the frame thickness in pixels.
REQ-006 SHALL have parameter FRAME_COLOR, default 12'hFFF, meaning the 12-bit frame colour.
REQ-007 SHALL have parameter BAR_COLOR, default 12'h0F0, meaning the 12-bit progress-bar colour.
REQ-008 SHALL have parameter DURATION, default 32500000, meaning the active period in clk cycles (at least 1).
REQ-009 SHALL have parameter TRIG_STATE, default 4'h0, meaning the state_in value that arms the overlay.
REQ-010 SHALL have parameter RETRIGGER, default 0, meaning that when it is 1 a trigger while busy restarts the timer.
REQ-011 SHALL have port clk, input, 1 bit, the system pixel clock.
REQ-012 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-013 SHALL have port hcount_in, input, 11 bits, the current pixel column.
REQ-014 SHALL have port vcount_in, input, 10 bits, the current pixel row.
REQ-015 SHALL have port state_in, input, 4 bits, the game state.
REQ-016 SHALL have port abort_in, input, 1 bit, which cancels an active overlay.
REQ-017 SHALL have port busy_out, output, 1 bit, which is high while the overlay is active.
REQ-018 SHALL have port finished_out, output, 1 bit, a one-cycle pulse on normal completion.
REQ-019 SHALL have port pixel_out, output, 12 bits, the overlay colour, or 0 where the overlay is transparent.

Function
REQ-020 SHALL hold a registered copy prev_state of state_in, updated every non-reset cycle; a trigger is the condition state_in==TRIG_STATE and prev_state!=TRIG_STATE.
REQ-021 SHALL implement the states IDLE and ACTIVE; busy_out SHALL equal (state==ACTIVE).
REQ-022 SHALL, in IDLE on a trigger, go to ACTIVE on the next edge with count=0 and fill=0.
REQ-023 SHALL, in ACTIVE, increment count by 1 per cycle; when count==DURATION-1 it SHALL go to IDLE, clear count and assert finished_out for exactly the next cycle.
REQ-024 SHALL, on a trigger in ACTIVE, clear count and fill and stay ACTIVE when RETRIGGER=1, and ignore the trigger when RETRIGGER=0.
REQ-025 SHALL, on abort_in=1 in ACTIVE, go to IDLE, clear count and fill, and not pulse finished_out.
REQ-026 SHALL give abort priority over completion and retrigger in the same cycle, so that no finished pulse occurs.
REQ-027 SHALL give a trigger in the same cycle as completion no effect beyond completion when RETRIGGER=0; when RETRIGGER=1 the retrigger wins, with no finished pulse.
REQ-028 SHALL ignore abort_in in IDLE.
REQ-029 SHALL use the inner bar width IW=W-2*BORDER and the constant STEP=max(1,DURATION/IW), and advance fill by 1 every STEP active cycles, saturating at IW.
REQ-030 SHALL define a frame pixel as inside [X0,X0+W) x [Y0,Y0+H) but not inside [X0+BORDER,X0+W-BORDER) x [Y0+BORDER,Y0+H-BORDER).
REQ-031 SHALL define a bar pixel as inside the inner rectangle with hcount_in < X0+BORDER+fill.
REQ-032 SHALL register pixel_out with 1-cycle latency from hcount_in/vcount_in: FRAME_COLOR for frame pixels, BAR_COLOR for bar pixels, and 0 otherwise or when busy_out=0.
REQ-033 SHALL perform all comparisons unsigned at 12 bits or wider with no wrap, and size count to ceil(log2(DURATION+1)) bits.

Reset
REQ-034 SHALL, on rst=1 at a clk edge, set state=IDLE, count=0, fill=0, busy_out=0, finished_out=0, pixel_out=0 and prev_state=~TRIG_STATE.
REQ-035 SHALL, when reset is asserted mid-ACTIVE, abort without a finished pulse; if state_in==TRIG_STATE on the first cycle after reset, that SHALL count as a trigger.

Verification
REQ-036 SHALL cover nominal completion with DURATION=20: state_in 5->0 at cycle t gives busy_out high from t+1 to t+20 and finished_out high only at t+21.
REQ-037 SHALL cover abort: abort_in at active count 7 gives busy_out low on the next cycle and finished_out never high.
REQ-038 SHALL cover retrigger: with RETRIGGER=1, state_in 0->3->0 at count 10 resets count and finishes 20 cycles after the retrigger; with RETRIGGER=0 the bench SHALL confirm completion on the original schedule.
REQ-039 SHALL cover the pixel map with X0=10, Y0=10, W=20, H=10, BORDER=2 while busy: (10,10)->FRAME_COLOR, (15,15) with fill=0 ->0, (12,12) with fill=5 ->BAR_COLOR, and (9,10)->0, each one cycle later.
REQ-040 SHALL cover bar saturation with DURATION=100 and IW=16 (STEP=6): fill=16 after 96 cycles and stays 16 until completion.
REQ-041 SHALL cover reset mid-ACTIVE at count 5: all outputs are 0 on the next cycle, with no finished pulse.
